serv_wb_arbiter: RTL and testbench

Sequential arbiter that shares one Wishbone classic master port between the core's instruction bus (ibus) and data bus (dbus). It sits between the fetch/decode front end and the single system bus. Each transaction is registered and owned by one requester from grant until ack, abort or timeout. The ibus ack is the fetch completion that drives the decoder's instruction-latch enable.

---
 rtl/serv_wb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_serv_wb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_wb_arbiter.sv
// Purpose : shares one Wishbone classic master between the ibus (fetch) and dbus (load/store) requesters.
// Latency : request seen at edge N -> o_wb_cyc after N; i_wb_ack at edge M -> o_*_ack after M.
// Backpr. : the non-owner is held off until the owner's ack/abort/timeout returns the arbiter to IDLE.
// Ports   : clk/i_rst_n (async active-low); i_ibus_* / o_ibus_* fetch side; i_dbus_* / o_dbus_* data side;
//           o_wb_* / i_wb_* shared master. o_*_err pulses only when SERV_ARB_TIMEOUT_EN is defined.
// Options : FAIR=1 round-robin on contention, FAIR=0 dbus wins; `define SERV_ARB_TIMEOUT_EN enables the
//           TIMEOUT_W-bit bus timeout, otherwise transactions wait indefinitely and errs are tied to 0.
module serv_wb_arbiter #(
   parameter int unsigned FAIR      = 1,
   parameter int unsigned TIMEOUT_W = 8
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_ibus_adr,
   input  logic        i_ibus_cyc,
   output logic [31:0] o_ibus_rdt,
   output logic        o_ibus_ack,
   output logic        o_ibus_err,
   input  logic [31:0] i_dbus_adr,
   input  logic [31:0] i_dbus_dat,
   input  logic [3:0]  i_dbus_sel,
   input  logic        i_dbus_we,
   input  logic        i_dbus_cyc,
   output logic [31:0] o_dbus_rdt,
   output logic        o_dbus_ack,
   output logic        o_dbus_err,
   output logic [31:0] o_wb_adr,
   output logic [31:0] o_wb_dat,
   output logic [3:0]  o_wb_sel,
   output logic        o_wb_we,
   output logic        o_wb_cyc,
   input  logic [31:0] i_wb_rdt,
   input  logic        i_wb_ack
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_IBUS = 2'd1, S_DBUS = 2'd2} state_t;

   state_t      r_state, w_state_nxt;
   logic        r_last_dbus;   // 1 = most recent grant went to dbus
   logic        r_ibus_ack, r_dbus_ack, r_wb_cyc, r_wb_we;
   logic [31:0] r_ibus_rdt, r_dbus_rdt, r_wb_adr, r_wb_dat;
   logic [3:0]  r_wb_sel;

   logic w_ibus_elig, w_dbus_elig;
   logic w_grant_i, w_grant_d;
   logic w_own_cyc, w_done, w_abort, w_tmo;

   // A requester whose ack/err is high this cycle is still dropping cyc, so it is not eligible yet.
   assign w_ibus_elig = i_ibus_cyc & ~r_ibus_ack & ~o_ibus_err;
   assign w_dbus_elig = i_dbus_cyc & ~r_dbus_ack & ~o_dbus_err;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_done      = 1'b0;
      w_abort     = 1'b0;
      w_own_cyc   = (r_state == S_DBUS) ? i_dbus_cyc : i_ibus_cyc;
      case (r_state)
         S_IDLE: begin
            // dbus wins contention when unfair, or when ibus had the previous grant.
            w_grant_d = w_dbus_elig & (~w_ibus_elig | (FAIR == 0) | ~r_last_dbus);
            w_grant_i = w_ibus_elig & ~w_grant_d;
            if (w_grant_d)
               w_state_nxt = S_DBUS;
            else if (w_grant_i)
               w_state_nxt = S_IBUS;
         end
         S_IBUS, S_DBUS: begin
            // Priority: slave ack, then owner abort, then timeout.
            w_done  = i_wb_ack;
            w_abort = ~i_wb_ack & ~w_own_cyc;
            if (w_done | w_abort | w_tmo)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_last_dbus <= 1'b0;
         r_ibus_ack  <= 1'b0;
         r_dbus_ack  <= 1'b0;
         r_ibus_rdt  <= 32'h0;
         r_dbus_rdt  <= 32'h0;
         r_wb_cyc    <= 1'b0;
         r_wb_adr    <= 32'h0;
         r_wb_dat    <= 32'h0;
         r_wb_sel    <= 4'h0;
         r_wb_we     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ibus_ack <= 1'b0;
         r_dbus_ack <= 1'b0;
         if (w_grant_d) begin
            r_wb_cyc    <= 1'b1;
            r_wb_adr    <= i_dbus_adr;
            r_wb_dat    <= i_dbus_dat;
            r_wb_sel    <= i_dbus_sel;
            r_wb_we     <= i_dbus_we;
            r_last_dbus <= 1'b1;
         end else if (w_grant_i) begin
            r_wb_cyc    <= 1'b1;
            r_wb_adr    <= i_ibus_adr;
            r_wb_dat    <= 32'h0;
            r_wb_sel    <= 4'hF;
            r_wb_we     <= 1'b0;
            r_last_dbus <= 1'b0;
         end
         if (w_done) begin
            r_wb_cyc <= 1'b0;
            if (r_state == S_IBUS) begin
               r_ibus_ack <= 1'b1;
               r_ibus_rdt <= i_wb_rdt;
            end else begin
               r_dbus_ack <= 1'b1;
               r_dbus_rdt <= i_wb_rdt;
            end
         end else if (w_abort) begin
            r_wb_cyc <= 1'b0;
         end else if (w_tmo) begin
            r_wb_cyc <= 1'b0;
            if (r_state == S_IBUS)
               r_ibus_rdt <= 32'h0;
            else
               r_dbus_rdt <= 32'h0;
         end
      end
   end

`ifdef SERV_ARB_TIMEOUT_EN
   // Firing one count early makes err appear on the edge the counter reaches all-ones,
   // i.e. 2^TIMEOUT_W-1 cycles after the grant.
   localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

   logic [TIMEOUT_W-1:0] r_tmo_cnt;
   logic                 r_ibus_err, r_dbus_err;

   assign w_tmo = (r_state != S_IDLE) & ~i_wb_ack & w_own_cyc & (r_tmo_cnt == TMO_LAST);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tmo_cnt  <= '0;
         r_ibus_err <= 1'b0;
         r_dbus_err <= 1'b0;
      end else begin
         r_ibus_err <= w_tmo & (r_state == S_IBUS);
         r_dbus_err <= w_tmo & (r_state == S_DBUS);
         if (w_grant_i | w_grant_d)
            r_tmo_cnt <= '0;
         else if ((r_state != S_IDLE) & ~i_wb_ack)
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign o_ibus_err = r_ibus_err;
   assign o_dbus_err = r_dbus_err;
`else
   // Keeps the width parameter referenced in builds without the timeout.
   localparam int unsigned tmo_w_unused = TIMEOUT_W;

   assign w_tmo      = 1'b0;
   assign o_ibus_err = 1'b0;
   assign o_dbus_err = 1'b0;
`endif

   assign o_ibus_rdt = r_ibus_rdt;
   assign o_ibus_ack = r_ibus_ack;
   assign o_dbus_rdt = r_dbus_rdt;
   assign o_dbus_ack = r_dbus_ack;
   assign o_wb_adr   = r_wb_adr;
   assign o_wb_dat   = r_wb_dat;
   assign o_wb_sel   = r_wb_sel;
   assign o_wb_we    = r_wb_we;
   assign o_wb_cyc   = r_wb_cyc;

endmodule

// File: tb/tb_serv_wb_arbiter.sv
// Purpose : directed self-checking bench for serv_wb_arbiter (FAIR=1 main instance, FAIR=0 side instance).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpr. : the bench plays both requesters and the slave; every wait is a fixed cycle count.
module tb_serv_wb_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_rst_n;
   logic [31:0] i_ibus_adr, i_dbus_adr, i_dbus_dat, i_wb_rdt;
   logic [3:0]  i_dbus_sel;
   logic        i_ibus_cyc, i_dbus_cyc, i_dbus_we, i_wb_ack;
   logic [31:0] o_ibus_rdt, o_dbus_rdt, o_wb_adr, o_wb_dat;
   logic [3:0]  o_wb_sel;
   logic        o_ibus_ack, o_ibus_err, o_dbus_ack, o_dbus_err, o_wb_we, o_wb_cyc;

   // FAIR=0 instance
   logic        f_ibus_cyc, f_dbus_cyc, f_wb_ack;
   logic [31:0] f_ibus_rdt, f_dbus_rdt, f_wb_adr, f_wb_dat;
   logic [3:0]  f_wb_sel;
   logic        f_ibus_ack, f_ibus_err, f_dbus_ack, f_dbus_err, f_wb_we, f_wb_cyc;

   int n_chk = 0;
   int n_err = 0;

   serv_wb_arbiter #(.FAIR(1), .TIMEOUT_W(4)) u_dut (
      .clk(clk), .i_rst_n(i_rst_n),
      .i_ibus_adr(i_ibus_adr), .i_ibus_cyc(i_ibus_cyc),
      .o_ibus_rdt(o_ibus_rdt), .o_ibus_ack(o_ibus_ack), .o_ibus_err(o_ibus_err),
      .i_dbus_adr(i_dbus_adr), .i_dbus_dat(i_dbus_dat), .i_dbus_sel(i_dbus_sel),
      .i_dbus_we(i_dbus_we), .i_dbus_cyc(i_dbus_cyc),
      .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack), .o_dbus_err(o_dbus_err),
      .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
      .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc),
      .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack)
   );

   serv_wb_arbiter #(.FAIR(0), .TIMEOUT_W(4)) u_dut_unfair (
      .clk(clk), .i_rst_n(i_rst_n),
      .i_ibus_adr(32'h0000_0040), .i_ibus_cyc(f_ibus_cyc),
      .o_ibus_rdt(f_ibus_rdt), .o_ibus_ack(f_ibus_ack), .o_ibus_err(f_ibus_err),
      .i_dbus_adr(32'h0000_0080), .i_dbus_dat(32'h0), .i_dbus_sel(4'hF),
      .i_dbus_we(1'b0), .i_dbus_cyc(f_dbus_cyc),
      .o_dbus_rdt(f_dbus_rdt), .o_dbus_ack(f_dbus_ack), .o_dbus_err(f_dbus_err),
      .o_wb_adr(f_wb_adr), .o_wb_dat(f_wb_dat), .o_wb_sel(f_wb_sel),
      .o_wb_we(f_wb_we), .o_wb_cyc(f_wb_cyc),
      .i_wb_rdt(32'h0), .i_wb_ack(f_wb_ack)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic seen_err;
      i_rst_n = 1'b0;
      i_ibus_adr = 32'h0; i_ibus_cyc = 1'b0;
      i_dbus_adr = 32'h0; i_dbus_dat = 32'h0; i_dbus_sel = 4'h0; i_dbus_we = 1'b0; i_dbus_cyc = 1'b0;
      i_wb_rdt = 32'h0; i_wb_ack = 1'b0;
      f_ibus_cyc = 1'b0; f_dbus_cyc = 1'b0; f_wb_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cyc", o_wb_cyc, 0);
      chk("rst_iack", o_ibus_ack, 0);
      chk("rst_dack", o_dbus_ack, 0);
      chk("rst_irdt", o_ibus_rdt, 0);
      chk("rst_drdt", o_dbus_rdt, 0);
      chk("rst_adr", o_wb_adr, 0);
      chk("rst_ierr", o_ibus_err, 0);
      i_rst_n = 1'b1;
      tick();
      chk("idle_cyc", o_wb_cyc, 0);

      // Single fetch, slave acks 3 cycles after cyc rises
      i_ibus_adr = 32'h100; i_ibus_cyc = 1'b1;
      tick();
      chk("fetch_cyc", o_wb_cyc, 1);
      chk("fetch_adr", o_wb_adr, 32'h100);
      chk("fetch_sel", o_wb_sel, 4'hF);
      chk("fetch_we", o_wb_we, 0);
      chk("fetch_dat", o_wb_dat, 0);
      tick();
      tick();
      chk("fetch_wait_cyc", o_wb_cyc, 1);
      chk("fetch_wait_ack", o_ibus_ack, 0);
      i_wb_ack = 1'b1; i_wb_rdt = 32'h0050_0093;
      tick();
      chk("fetch_ack", o_ibus_ack, 1);
      chk("fetch_rdt", o_ibus_rdt, 32'h0050_0093);
      chk("fetch_cyc_drop", o_wb_cyc, 0);
      chk("fetch_dack", o_dbus_ack, 0);
      i_wb_ack = 1'b0; i_ibus_cyc = 1'b0; i_wb_rdt = 32'hFFFF_FFFF;
      tick();
      chk("fetch_ack_pulse", o_ibus_ack, 0);
      chk("fetch_rdt_hold", o_ibus_rdt, 32'h0050_0093);

      // Contention with last grant = ibus: dbus first, ibus after one recovery cycle
      i_dbus_adr = 32'h3000; i_dbus_sel = 4'hF; i_dbus_we = 1'b0;
      i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
      tick();
      chk("cont1_cyc", o_wb_cyc, 1);
      chk("cont1_adr", o_wb_adr, 32'h3000);
      i_wb_ack = 1'b1; i_wb_rdt = 32'hAAAA_5555;
      tick();
      chk("cont1_dack", o_dbus_ack, 1);
      chk("cont1_drdt", o_dbus_rdt, 32'hAAAA_5555);
      chk("cont1_iack", o_ibus_ack, 0);
      chk("cont1_irdt_hold", o_ibus_rdt, 32'h0050_0093);
      i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;
      tick();
      chk("cont1_igrant_cyc", o_wb_cyc, 1);
      chk("cont1_igrant_adr", o_wb_adr, 32'h100);
      chk("cont1_dack_pulse", o_dbus_ack, 0);
      i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_0013;
      tick();
      chk("cont1_iack2", o_ibus_ack, 1);
      chk("cont1_irdt2", o_ibus_rdt, 32'h13);
      chk("cont1_drdt_hold", o_dbus_rdt, 32'hAAAA_5555);
      i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
      tick();

      // Dbus write, then requester changes its inputs mid-transaction
      i_dbus_adr = 32'h2000; i_dbus_dat = 32'hDEAD_BEEF; i_dbus_sel = 4'b0011; i_dbus_we = 1'b1;
      i_dbus_cyc = 1'b1;
      tick();
      chk("wr_cyc", o_wb_cyc, 1);
      chk("wr_adr", o_wb_adr, 32'h2000);
      chk("wr_dat", o_wb_dat, 32'hDEAD_BEEF);
      chk("wr_sel", o_wb_sel, 4'b0011);
      chk("wr_we", o_wb_we, 1);
      i_dbus_adr = 32'h5555_0000; i_dbus_dat = 32'h0;
      tick();
      chk("wr_adr_hold", o_wb_adr, 32'h2000);
      chk("wr_dat_hold", o_wb_dat, 32'hDEAD_BEEF);
      i_wb_ack = 1'b1; i_wb_rdt = 32'h0;
      tick();
      chk("wr_dack", o_dbus_ack, 1);
      i_wb_ack = 1'b0; i_dbus_cyc = 1'b0; i_dbus_we = 1'b0; i_dbus_sel = 4'hF;
      tick();

      // Dbus abort, then a stray slave ack
      i_dbus_adr = 32'h2004; i_dbus_cyc = 1'b1;
      tick();
      chk("ab_cyc", o_wb_cyc, 1);
      chk("ab_adr", o_wb_adr, 32'h2004);
      i_dbus_cyc = 1'b0;
      tick();
      chk("ab_cyc_drop", o_wb_cyc, 0);
      chk("ab_dack", o_dbus_ack, 0);
      i_wb_ack = 1'b1; i_wb_rdt = 32'h77;
      tick();
      chk("stray_dack", o_dbus_ack, 0);
      chk("stray_iack", o_ibus_ack, 0);
      chk("stray_cyc", o_wb_cyc, 0);
      chk("stray_drdt", o_dbus_rdt, 32'h0);
      i_wb_ack = 1'b0;
      tick();

      // Contention with last grant = dbus: ibus wins this time
      i_ibus_adr = 32'h104; i_dbus_adr = 32'h3000;
      i_ibus_cyc = 1'b1; i_dbus_cyc = 1'b1;
      tick();
      chk("cont2_adr", o_wb_adr, 32'h104);
      chk("cont2_sel", o_wb_sel, 4'hF);
      i_wb_ack = 1'b1; i_wb_rdt = 32'h00A0_0113;
      tick();
      chk("cont2_iack", o_ibus_ack, 1);
      i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
      tick();
      chk("cont2_dgrant_adr", o_wb_adr, 32'h3000);
      chk("cont2_dgrant_cyc", o_wb_cyc, 1);
      i_wb_ack = 1'b1;
      tick();
      chk("cont2_dack", o_dbus_ack, 1);
      i_wb_ack = 1'b0; i_dbus_cyc = 1'b0;
      tick();

      // Fetch that the slave never acks
      i_ibus_adr = 32'h200; i_ibus_cyc = 1'b1;
      tick();
      chk("tmo_grant", o_wb_cyc, 1);
`ifdef SERV_ARB_TIMEOUT_EN
      repeat (14) tick();
      chk("tmo_pre_err", o_ibus_err, 0);
      chk("tmo_pre_cyc", o_wb_cyc, 1);
      tick();
      chk("tmo_err", o_ibus_err, 1);
      chk("tmo_cyc", o_wb_cyc, 0);
      chk("tmo_iack", o_ibus_ack, 0);
      chk("tmo_irdt", o_ibus_rdt, 32'h0);
      i_ibus_cyc = 1'b0;
      tick();
      chk("tmo_err_pulse", o_ibus_err, 0);
`else
      seen_err = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         seen_err = seen_err | o_ibus_err;
      end
      chk("notmo_err", seen_err, 0);
      chk("notmo_cyc", o_wb_cyc, 1);
      i_wb_ack = 1'b1; i_wb_rdt = 32'h1111_2222;
      tick();
      chk("notmo_iack", o_ibus_ack, 1);
      chk("notmo_irdt", o_ibus_rdt, 32'h1111_2222);
      i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
      tick();
`endif
      tick();

      // FAIR=0: every contended grant goes to dbus
      for (int n = 0; n < 3; n++) begin
         f_ibus_cyc = 1'b1; f_dbus_cyc = 1'b1;
         tick();
         chk("unfair_adr", f_wb_adr, 32'h80);
         f_wb_ack = 1'b1;
         tick();
         chk("unfair_dack", f_dbus_ack, 1);
         chk("unfair_iack", f_ibus_ack, 0);
         f_wb_ack = 1'b0; f_ibus_cyc = 1'b0; f_dbus_cyc = 1'b0;
         tick();
         tick();
      end

      // Asynchronous reset in the middle of a dbus transaction
      i_dbus_adr = 32'h3000; i_dbus_cyc = 1'b1;
      tick();
      chk("rstmid_pre_cyc", o_wb_cyc, 1);
      #2;
      i_rst_n = 1'b0;
      i_ibus_adr = 32'h300; i_ibus_cyc = 1'b1;
      #1;
      chk("rstmid_cyc", o_wb_cyc, 0);
      chk("rstmid_adr", o_wb_adr, 32'h0);
      chk("rstmid_irdt", o_ibus_rdt, 32'h0);
      chk("rstmid_drdt", o_dbus_rdt, 32'h0);
      i_wb_ack = 1'b1;
      tick();
      chk("rstmid_dack", o_dbus_ack, 0);
      i_rst_n = 1'b1; i_dbus_cyc = 1'b0; i_wb_ack = 1'b0;
      tick();
      chk("rstpost_cyc", o_wb_cyc, 1);
      chk("rstpost_adr", o_wb_adr, 32'h300);
      i_wb_ack = 1'b1; i_wb_rdt = 32'h0000_0073;
      tick();
      chk("rstpost_iack", o_ibus_ack, 1);
      chk("rstpost_irdt", o_ibus_rdt, 32'h73);
      i_wb_ack = 1'b0; i_ibus_cyc = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
